new_descrambler: RTL and testbench

Self-synchronizing serial descrambler for the PRBS-15 polynomial x^15 + x^14 + 1. It sits directly after the serial receive front-end. It removes the multiplicative scrambling applied by the matching transmit-side scrambler and presents one descrambled bit per enabled clock. The 15-bit history register is exposed for debug and for observation by the checker.

---
 rtl/new_descrambler.sv | 66 ++++++
 tb/tb_new_descrambler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/new_descrambler.sv
// new_descrambler: self-synchronizing serial descrambler for x^15 + x^14 + 1.
// The history register holds the raw received (scrambled) bits, so the
// descrambler locks onto any transmitter seed once 15 bits have been seen.
// Optional build macro: NEW_DESCRAMBLER_SYNC_EN adds a saturating fill
// counter and the `synced` output reporting a fully loaded history.
module new_descrambler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        de_serial_in,
    output logic        descrambled_out,
    output logic [14:0] dout
`ifdef NEW_DESCRAMBLER_SYNC_EN
    ,
    output logic        synced
`endif
);

    localparam int unsigned WIDTH = 15;
    localparam int unsigned TAP_A = 13;
    localparam int unsigned TAP_B = 14;

    logic descramble_bit_c;

    // Multiplicative descramble: received bit XOR the two tapped history bits
    assign descramble_bit_c = de_serial_in ^ dout[TAP_A] ^ dout[TAP_B];

    // History shift register and registered output; both hold while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout            <= '0;
            descrambled_out <= 1'b0;
        end else if (enable) begin
            dout            <= {dout[WIDTH-2:0], de_serial_in};
            descrambled_out <= descramble_bit_c;
        end
    end

`ifdef NEW_DESCRAMBLER_SYNC_EN
    localparam int unsigned FILL_W   = 4;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);

    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next_c;

    // Saturating count of bits captured since reset
    always_comb begin
        fill_next_c = fill;
        if (fill != FILL_MAX) begin
            fill_next_c = fill + FILL_W'(1);
        end
    end

    // Fill counter and synced flag; synced sticks until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill   <= '0;
            synced <= 1'b0;
        end else if (enable) begin
            fill   <= fill_next_c;
            synced <= (fill_next_c == FILL_MAX);
        end
    end
`endif

endmodule

// File: tb/tb_new_descrambler.sv
// tb_new_descrambler: directed, table-driven bench for new_descrambler.
// Works in both builds; synced checks are compiled in with NEW_DESCRAMBLER_SYNC_EN.
module tb_new_descrambler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        de_serial_in;
    logic        descrambled_out;
    logic [14:0] dout;
    logic        synced;

    int unsigned n_cmp;
    int unsigned n_err;

    new_descrambler dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .de_serial_in    (de_serial_in),
        .descrambled_out (descrambled_out),
        .dout            (dout)
`ifdef NEW_DESCRAMBLER_SYNC_EN
        ,
        .synced          (synced)
`endif
    );

`ifndef NEW_DESCRAMBLER_SYNC_EN
    assign synced = 1'b0;
`endif

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        din;
        logic        exp_out;
        logic [14:0] exp_dout;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_sync(input string name, input logic exp);
`ifdef NEW_DESCRAMBLER_SYNC_EN
        chk(name, 32'(synced), 32'(exp));
`endif
    endtask

    // Drive one bit at the falling edge, sample just after the rising edge
    task automatic step(input logic en, input logic d);
        @(negedge clk);
        enable       = en;
        de_serial_in = d;
        @(posedge clk);
        #1;
    endtask

    // Hold reset across a few edges with random inputs, release at a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enable       = 1'($urandom);
            de_serial_in = 1'($urandom);
            @(negedge clk);
        end
        rst    = 1'b1;
        enable = 1'b0;
    endtask

    initial begin
        logic [14:0] s;
        logic        p;
        logic        sb;
        logic        d;

        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        enable       = 1'b0;
        de_serial_in = 1'b0;

        // Short pattern, enable gap with toggling input, then resume
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 15'h0001};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 15'h0002};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 15'h0005};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 15'h000B};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 15'h0016};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 15'h002C};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 15'h0059};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 15'h00B3};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 15'h00B3};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 15'h00B3};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 15'h00B3};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 15'h0166};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 15'h02CD};

        // Reset defaults under random inputs
        do_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable       = 1'($urandom);
            de_serial_in = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_dout", 32'(dout), 32'h0);
            chk("rst_out", 32'(descrambled_out), 32'h0);
            chk_sync("rst_synced", 1'b0);
            @(negedge clk);
        end
        rst    = 1'b1;
        enable = 1'b0;

        // Table: short pattern, gaps, resumed stream
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].din);
            chk($sformatf("tbl%0d_out", i), 32'(descrambled_out), 32'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
            chk_sync($sformatf("tbl%0d_synced", i), 1'b0);
        end

        // Tap check: fifteen ones, then 0 and 1
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("tap%0d_out", i), 32'(descrambled_out), (i == 14) ? 32'h0 : 32'h1);
            chk_sync($sformatf("tap%0d_synced", i), (i == 14));
        end
        chk("tap_dout", 32'(dout), 32'h7FFF);
        step(1'b1, 1'b0);
        chk("tap_zero_out", 32'(descrambled_out), 32'h0);
        chk_sync("tap_zero_synced", 1'b1);
        step(1'b1, 1'b1);
        chk("tap_one_out", 32'(descrambled_out), 32'h1);
        chk("tap_one_dout", 32'(dout), 32'h7FFD);

        // Round trip against a model scrambler with a nonzero seed
        do_reset();
        s = 15'h4A5F;
        for (int i = 0; i < 200; i++) begin
            p  = 1'($urandom);
            sb = p ^ s[13] ^ s[14];
            s  = {s[13:0], sb};
            step(1'b1, sb);
            if (i >= 15) chk($sformatf("rt%0d", i + 1), 32'(descrambled_out), 32'(p));
        end
        chk("rt_dout_state", 32'(dout), 32'(s));

        // Asynchronous reset between edges clears outputs immediately
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_dout", 32'(dout), 32'h0);
        chk("async_out", 32'(descrambled_out), 32'h0);
        chk_sync("async_synced", 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Mid-stream reset after 40 bits; history and sync restart from bit 1
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom));
        chk_sync("mid_pre_synced", 1'b1);
        do_reset();
        chk("mid_dout", 32'(dout), 32'h0);
        chk_sync("mid_synced", 1'b0);
        for (int i = 0; i < 15; i++) begin
            d = 1'($urandom);
            step(1'b1, d);
            if (i < 14) chk($sformatf("mid%0d_echo", i), 32'(descrambled_out), 32'(d));
            chk_sync($sformatf("mid%0d_synced", i), (i == 14));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
